// File: rtl/slave_out_port.sv
// slave_out_port: serial read-data transmitter on the slave side of the bus.
// It takes parallel words from the slave core through a one-word holding
// register. For each word it does an s_valid/m_ready handshake and then
// shifts the word out on tx_data, LSB first, one bit per clock. After
// burst_size words it pulses tx_done.
//
// Optional feature (define SLAVE_OUT_TIMEOUT_EN): handshake-wait timeout.
// The burst is aborted with a tx_abort pulse after TIMEOUT cycles of
// m_ready=0 while s_valid=1.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   m_ready           master ready to receive a word
//   tx_data           serial data to master, LSB first
//   s_valid           a word is ready to send (handshake phase only)
//   start             core pulse that begins a burst (sampled in IDLE only)
//   burst_size        number of words in the burst, sampled with start
//   data_in           next word from the core
//   data_in_valid     data_in is valid
//   data_in_ready     holding register is empty
//   busy              burst in progress
//   tx_done           one-cycle pulse after the last bit of the burst
//   tx_abort          one-cycle pulse on handshake timeout (0 without macro)
module slave_out_port #(
  parameter int unsigned WORD_SIZE  = 8,
  parameter int unsigned BURST_SIZE = 15,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m_ready,
  output logic                  tx_data,
  output logic                  s_valid,
  input  logic                  start,
  input  logic [BURST_SIZE-1:0] burst_size,
  input  logic [WORD_SIZE-1:0]  data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic                  busy,
  output logic                  tx_done,
  output logic                  tx_abort
);

  localparam int unsigned BIT_CNT_W = $clog2(WORD_SIZE + 1);

  typedef enum logic [1:0] {IDLE, HS, SEND, DONE} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [WORD_SIZE-1:0]   hold;
  logic                   hold_full;
  logic [WORD_SIZE-1:0]   shift;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [BURST_SIZE-1:0]  words_left;
  logic                   accept;
  logic                   hs_fire;
  logic                   word_end;
  logic                   timeout_hit;

  // Status outputs decode flops only; nothing from the inputs reaches them.
  assign s_valid       = (state == HS) && hold_full;
  assign data_in_ready = ~hold_full;
  assign busy          = (state != IDLE);
  assign tx_done       = (state == DONE);

  assign accept   = data_in_valid && !hold_full;
  assign hs_fire  = s_valid && m_ready;
  // Edge that ends the period of the last bit of the current word.
  assign word_end = (state == SEND) && (bit_cnt == BIT_CNT_W'(WORD_SIZE));

`ifdef SLAVE_OUT_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt;
  logic            abort_q;

  // Fires on the edge where the stall count would reach TIMEOUT.
  assign timeout_hit = s_valid && !m_ready && (to_cnt == TO_W'(TIMEOUT - 1));
  assign tx_abort    = abort_q;

  // Handshake-wait counter and abort pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt  <= '0;
      abort_q <= 1'b0;
    end else begin
      abort_q <= timeout_hit;
      if ((state != HS) || hs_fire || timeout_hit) begin
        to_cnt <= '0;
      end else if (s_valid && !m_ready) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg  = ^32'(TIMEOUT);
  assign timeout_hit = 1'b0;
  assign tx_abort    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (burst_size == '0) ? DONE : HS;
        end
      end
      HS: begin
        if (timeout_hit) begin
          state_next = IDLE;
        end else if (hs_fire) begin
          state_next = SEND;
        end
      end
      SEND: begin
        if (word_end) begin
          state_next = (words_left == BURST_SIZE'(1)) ? DONE : HS;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Holding register, shifter, bit counter and word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold       <= '0;
      hold_full  <= 1'b0;
      shift      <= '0;
      tx_data    <= 1'b0;
      bit_cnt    <= '0;
      words_left <= '0;
    end else begin
      // Acceptance needs an empty hold and the handshake needs a full one,
      // so the two never touch hold on the same edge.
      if (accept) begin
        hold      <= data_in;
        hold_full <= 1'b1;
      end

      if (hs_fire) begin
        tx_data   <= hold[0];
        shift     <= hold >> 1;
        hold_full <= 1'b0;
        bit_cnt   <= BIT_CNT_W'(1);
      end else if ((state == SEND) && (bit_cnt < BIT_CNT_W'(WORD_SIZE))) begin
        tx_data <= shift[0];
        shift   <= shift >> 1;
        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      end

      if (timeout_hit) begin
        hold_full <= 1'b0;
      end

      if ((state == IDLE) && start && (burst_size != '0)) begin
        words_left <= burst_size;
      end else if (word_end && (words_left != BURST_SIZE'(1))) begin
        words_left <= words_left - BURST_SIZE'(1);
      end
    end
  end

endmodule
